collision_scanner: RTL and testbench
====================================

// Module: collision_scanner
// PURPOSE
// Parametrised successor of the single-pair side-contact detector. Sequentially scans a tile table of
// N_TILES ground blocks against one player sprite and produces per-side contact flags and the first
// supporting tile index. Sits between the tile-map ROM and the player movement/gravity logic.
// Runs one scan per start pulse (typically once per frame).
// PARAMETERS
// X_W      10  x coordinate width (pixels)
// Y_W      9   y coordinate width (pixels)
// PW       23  player sprite width
// PH       45  player sprite height
// TW       25  tile width
// TH       24  tile height
// MARGIN   2   edge inset ignored for overlap tests (corner tolerance)
// N_TILES  16  table entries scanned; >=1
// IDX_W    $clog2(N_TILES) (min 1)  tile index width
// PORTS
// clk        in   1      system clock
// rst        in   1      synchronous active-high reset
// start      in   1      request scan; sampled only in IDLE
// x_player   in   X_W    player top-left x
// y_player   in   Y_W    player top-left y
// tile_addr  out  IDX_W  tile table read address
// tile_x     in   X_W    tile top-left x, valid 1 cycle after tile_addr
// tile_y     in   Y_W    tile top-left y, valid 1 cycle after tile_addr
// tile_en    in   1      tile slot populated, valid with tile_x/tile_y; 0 = skip
// busy       out  1      scan in progress
// done       out  1      one-cycle pulse: results updated this cycle
// is_collision out 4     [0] down [1] up [2] right [3] left; held until next done
// hit_idx    out  IDX_W  lowest index giving down contact; 0 if none
// hit_valid  out  1      down contact found (== is_collision[0])
// BEHAVIOUR
// - Reset (sync, rst=1 at edge): state IDLE, tile_addr=0, busy=0, done=0, is_collision=0, hit_idx=0,
//   hit_valid=0, accumulators cleared. Reset mid-scan aborts; no done pulse is produced.
// - FSM IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
//   IDLE: on start=1 latch x_player/y_player, clear accumulators, tile_addr=0, busy=1, go SCAN.
//   SCAN: each cycle evaluate tile for previous address (1-cycle read latency), increment tile_addr;
//   after issuing address N_TILES-1 go DRAIN (tile_addr holds N_TILES-1).
//   DRAIN: evaluate last tile. DONE: register accumulators to outputs, done=1, busy=0, go IDLE.
// - Latency: start sampled at edge 0 -> done high in cycle N_TILES+2 (16 tiles: cycle 18).
// - start while busy ignored; player inputs changing during scan ignored (latched copy used).
// - Arithmetic: all sums in X_W+1 / Y_W+1 bits, zero-extended; no wrap-around (tile at y<PH can still
//   be tested correctly). Let xp,yp latched; xt,yt,en from table.
//   Hoverlap = xp+PW > xt+MARGIN && xp+MARGIN < xt+TW
//   Voverlap = yp+PH > yt+MARGIN && yp+MARGIN < yt+TH
//   down  = en && Hoverlap && yp+PH == yt
//   up    = en && Hoverlap && yp == yt+TH
//   right = en && Voverlap && xp+PW == xt
//   left  = en && Voverlap && xp == xt+TW
// - Flags OR-accumulate across tiles; hit_idx captures the first (lowest) index setting down; later
//   down hits do not overwrite.
// - Tiles with en=0 contribute nothing. N_TILES=1: SCAN lasts one cycle.
// - Outputs change only in DONE or reset; stable while busy.
// TESTING
// 1 rst high 2 cycles during scan -> busy=0, flags 0, no done pulse; next start scans normally.
// 2 player (100,55), tile3=(110,100,en=1), others en=0 -> done at cycle 18, is_collision=4'b0001,
//   hit_idx=3, hit_valid=1.
// 3 player (100,124), tile5=(100,100) -> 4'b0010; player (75,60), tile0=(98,50) -> 4'b0100;
//   player (123,60), tile0=(98,50) -> 4'b1000.
// 4 corner tolerance: player (79,55), tile=(100,100): xp+PW=102 not > 102 -> 4'b0000; x=80 -> 4'b0001.
// 5 down hits at tiles 2 and 9 plus right hit at tile 7 -> 4'b0101, hit_idx=2; same geometry with
//   tile2 en=0 -> hit_idx=9.
// 6 wrap check: player (10,0), tile (10,45) -> down=1; tile (10,20) y=0 up test: yt+TH=44 != 0 -> 0;
//   start pulses during busy -> exactly one done per accepted start.

Source files
------------

// File: rtl/collision_scanner_if.sv
// ---------------------------------------------------------------------------
// collision_scanner_if
// Bundles the scanner's control, player, tile-table and result signals.
//   start          request a scan (sampled only while the scanner is idle)
//   x_player/y_player  player sprite top-left corner
//   tile_addr      tile table read address (driven by the scanner)
//   tile_x/tile_y/tile_en  tile table read data, one cycle after tile_addr
//   busy/done      scan in progress / one-cycle result-update pulse
//   is_collision   [0] down [1] up [2] right [3] left
//   hit_idx/hit_valid  lowest tile index giving down contact
// Modports: master = the surrounding system, slave = the scanner.
// ---------------------------------------------------------------------------
interface collision_scanner_if #(
   parameter int X_W   = 10,
   parameter int Y_W   = 9,
   parameter int IDX_W = 4
);
   logic             start;
   logic [X_W-1:0]   x_player;
   logic [Y_W-1:0]   y_player;
   logic [IDX_W-1:0] tile_addr;
   logic [X_W-1:0]   tile_x;
   logic [Y_W-1:0]   tile_y;
   logic             tile_en;
   logic             busy;
   logic             done;
   logic [3:0]       is_collision;
   logic [IDX_W-1:0] hit_idx;
   logic             hit_valid;

   modport master (
      output start, x_player, y_player, tile_x, tile_y, tile_en,
      input  tile_addr, busy, done, is_collision, hit_idx, hit_valid
   );

   modport slave (
      input  start, x_player, y_player, tile_x, tile_y, tile_en,
      output tile_addr, busy, done, is_collision, hit_idx, hit_valid
   );
endinterface

// File: rtl/collision_scanner.sv
// ---------------------------------------------------------------------------
// collision_scanner
// Scans N_TILES entries of a tile table against one latched player sprite
// and reports OR-accumulated side-contact flags plus the lowest tile index
// that supports the player from below.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (aborts a scan, no done pulse)
//   bus   collision_scanner_if.slave (start, player position, tile table
//         read port, busy/done, is_collision, hit_idx, hit_valid)
// Timing: start sampled at edge 0 -> done high in cycle N_TILES+2.
// ---------------------------------------------------------------------------
module collision_scanner #(
   parameter int X_W     = 10,
   parameter int Y_W     = 9,
   parameter int PW      = 23,
   parameter int PH      = 45,
   parameter int TW      = 25,
   parameter int TH      = 24,
   parameter int MARGIN  = 2,
   parameter int N_TILES = 16
) (
   input logic                clk,
   input logic                rst,
   collision_scanner_if.slave bus
);
   localparam int IDX_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;
   localparam int XS    = X_W + 1;
   localparam int YS    = Y_W + 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TILES - 1);
   localparam logic [XS-1:0]    PW_X     = XS'(PW);
   localparam logic [XS-1:0]    TW_X     = XS'(TW);
   localparam logic [XS-1:0]    MG_X     = XS'(MARGIN);
   localparam logic [YS-1:0]    PH_Y     = YS'(PH);
   localparam logic [YS-1:0]    TH_Y     = YS'(TH);
   localparam logic [YS-1:0]    MG_Y     = YS'(MARGIN);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t           state, state_nxt;
   logic [X_W-1:0]   xp;
   logic [Y_W-1:0]   yp;
   logic             eval_v;      // tile data on the bus belongs to eval_idx
   logic [IDX_W-1:0] eval_idx;
   logic [3:0]       acc_flags;
   logic [IDX_W-1:0] acc_idx;

   // Operands widened by one bit so sums never wrap.
   logic [XS-1:0] xp_w, xt_w;
   logic [YS-1:0] yp_w, yt_w;
   logic          h_ovl, v_ovl;
   logic [3:0]    tile_flags;

   assign xp_w = {1'b0, xp};
   assign yp_w = {1'b0, yp};
   assign xt_w = {1'b0, bus.tile_x};
   assign yt_w = {1'b0, bus.tile_y};

   // Overlap tests shrink both spans by MARGIN so a corner graze is ignored.
   assign h_ovl = (xp_w + PW_X > xt_w + MG_X) && (xp_w + MG_X < xt_w + TW_X);
   assign v_ovl = (yp_w + PH_Y > yt_w + MG_Y) && (yp_w + MG_Y < yt_w + TH_Y);

   assign tile_flags[0] = bus.tile_en && h_ovl && (yp_w + PH_Y == yt_w);
   assign tile_flags[1] = bus.tile_en && h_ovl && (yp_w == yt_w + TH_Y);
   assign tile_flags[2] = bus.tile_en && v_ovl && (xp_w + PW_X == xt_w);
   assign tile_flags[3] = bus.tile_en && v_ovl && (xp_w == xt_w + TW_X);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: next state gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SCAN;
         SCAN:    if (bus.tile_addr == LAST_IDX) state_nxt = DRAIN;
         DRAIN:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.tile_addr    <= '0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.is_collision <= '0;
         bus.hit_idx      <= '0;
         bus.hit_valid    <= 1'b0;
         xp               <= '0;
         yp               <= '0;
         eval_v           <= 1'b0;
         eval_idx         <= '0;
         acc_flags        <= '0;
         acc_idx          <= '0;
      end else begin
         bus.done <= 1'b0;
         // Table read data arrives one cycle after the address was issued.
         eval_v   <= (state == SCAN);
         eval_idx <= bus.tile_addr;

         if (eval_v) begin
            acc_flags <= acc_flags | tile_flags;
            // Only the first down hit is kept; scan order is ascending.
            if (tile_flags[0] && !acc_flags[0]) acc_idx <= eval_idx;
         end

         case (state)
            IDLE: begin
               if (bus.start) begin
                  xp            <= bus.x_player;
                  yp            <= bus.y_player;
                  acc_flags     <= '0;
                  acc_idx       <= '0;
                  bus.tile_addr <= '0;
                  bus.busy      <= 1'b1;
               end
            end
            SCAN: begin
               if (bus.tile_addr != LAST_IDX) bus.tile_addr <= bus.tile_addr + 1'b1;
            end
            DONE: begin
               bus.is_collision <= acc_flags;
               bus.hit_idx      <= acc_idx;
               bus.hit_valid    <= acc_flags[0];
               bus.done         <= 1'b1;
               bus.busy         <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_collision_scanner.sv
// ---------------------------------------------------------------------------
// tb_collision_scanner
// Drives collision_scanner through its interface with a registered tile
// table, directed geometry cases and randomized tables, and compares the
// results with a rule-level reference model.
// ---------------------------------------------------------------------------
module tb_collision_scanner;
   localparam int X_W = 10, Y_W = 9, N = 16, IDX_W = 4;
   localparam int PW = 23, PH = 45, TW = 25, TH = 24, MG = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   collision_scanner_if #(.X_W(X_W), .Y_W(Y_W), .IDX_W(IDX_W)) bus ();

   collision_scanner #(
      .X_W(X_W), .Y_W(Y_W), .PW(PW), .PH(PH), .TW(TW), .TH(TH),
      .MARGIN(MG), .N_TILES(N)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Tile table with one cycle of read latency.
   logic [X_W-1:0] tab_x  [N];
   logic [Y_W-1:0] tab_y  [N];
   logic           tab_en [N];

   always @(posedge clk) begin
      bus.tile_x  <= tab_x[bus.tile_addr];
      bus.tile_y  <= tab_y[bus.tile_addr];
      bus.tile_en <= tab_en[bus.tile_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: plain integer geometry over the whole table.
   function automatic void model(input int xp, input int yp, output int flags, output int idx);
      flags = 0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         int xt, yt;
         bit hov, vov, d, u, r, l;
         if (!tab_en[i]) continue;
         xt  = int'(tab_x[i]);
         yt  = int'(tab_y[i]);
         hov = (xp + PW > xt + MG) && (xp + MG < xt + TW);
         vov = (yp + PH > yt + MG) && (yp + MG < yt + TH);
         d   = hov && (yp + PH == yt);
         u   = hov && (yp == yt + TH);
         r   = vov && (xp + PW == xt);
         l   = vov && (xp == xt + TW);
         if (d && (flags % 2 == 0)) idx = i;
         flags = flags | (int'(l) << 3) | (int'(r) << 2) | (int'(u) << 1) | int'(d);
      end
   endfunction

   task automatic clear_table();
      for (int i = 0; i < N; i++) begin
         tab_en[i] = 1'b0;
         tab_x[i]  = X_W'($urandom);
         tab_y[i]  = Y_W'($urandom);
      end
   endtask

   task automatic set_tile(input int i, input int x, input int y);
      tab_x[i]  = X_W'(x);
      tab_y[i]  = Y_W'(y);
      tab_en[i] = 1'b1;
   endtask

   // One scan: start, scramble player inputs and pulse start while busy,
   // then check latency, single done, output stability and results.
   task automatic run_scan(input string tag, input int xp, input int yp);
      int ef, ei, lat, dones, changes, busy_early, busy_done;
      logic [3:0] snap_f;
      logic [IDX_W-1:0] snap_i;
      model(xp, yp, ef, ei);
      @(negedge clk);
      bus.x_player = X_W'(xp);
      bus.y_player = Y_W'(yp);
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.x_player = X_W'($urandom);
      bus.y_player = Y_W'($urandom);
      snap_f = bus.is_collision;
      snap_i = bus.hit_idx;
      lat = -1; dones = 0; changes = 0; busy_early = 0; busy_done = 1;
      for (int cyc = 1; cyc <= 26; cyc++) begin
         @(negedge clk);
         if (cyc == 1) busy_early = int'(bus.busy);
         if (cyc == 5) bus.start = 1'b1;
         if (cyc == 6) bus.start = 1'b0;
         if (bus.done) begin
            dones++;
            if (lat < 0) begin
               lat       = cyc;
               busy_done = int'(bus.busy);
               check({tag, ".flags"}, 32'(bus.is_collision), 32'(ef));
               check({tag, ".hit_idx"}, 32'(bus.hit_idx), 32'(ei));
               check({tag, ".hit_valid"}, 32'(bus.hit_valid), 32'(ef % 2));
            end
         end else if (lat < 0 && (bus.is_collision !== snap_f || bus.hit_idx !== snap_i)) begin
            changes++;
         end
      end
      check({tag, ".latency"}, 32'(lat), 32'(N + 2));
      check({tag, ".dones"}, 32'(dones), 32'd1);
      check({tag, ".stable"}, 32'(changes), 32'd0);
      check({tag, ".busy_scan"}, 32'(busy_early), 32'd1);
      check({tag, ".busy_done"}, 32'(busy_done), 32'd0);
   endtask

   initial begin
      int xp, yp, dones;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.x_player = '0;
      bus.y_player = '0;
      clear_table();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset.busy", 32'(bus.busy), 32'd0);
      check("reset.done", 32'(bus.done), 32'd0);
      check("reset.flags", 32'(bus.is_collision), 32'd0);
      check("reset.hit_valid", 32'(bus.hit_valid), 32'd0);
      check("reset.tile_addr", 32'(bus.tile_addr), 32'd0);

      // Single down contact on tile 3.
      clear_table();
      set_tile(3, 110, 100);
      run_scan("down_t3", 100, 55);

      // Reset during a scan: abort, clear outputs, no done pulse.
      @(negedge clk);
      bus.x_player = X_W'(100);
      bus.y_player = Y_W'(55);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("midrst.busy", 32'(bus.busy), 32'd0);
      check("midrst.flags", 32'(bus.is_collision), 32'd0);
      check("midrst.hit_idx", 32'(bus.hit_idx), 32'd0);
      dones = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("midrst.no_done", 32'(dones), 32'd0);
      run_scan("after_rst", 100, 55);

      // Up, right and left contacts.
      clear_table();
      set_tile(5, 100, 100);
      run_scan("up", 100, 124);
      clear_table();
      set_tile(0, 98, 50);
      run_scan("right", 75, 60);
      run_scan("left", 123, 60);

      // Corner tolerance.
      clear_table();
      set_tile(0, 100, 100);
      run_scan("corner_miss", 79, 55);
      run_scan("corner_hit", 80, 55);

      // First down hit wins; disabling it exposes the next one.
      clear_table();
      set_tile(2, 100, 100);
      set_tile(7, 123, 60);
      set_tile(9, 110, 100);
      run_scan("multi", 100, 55);
      tab_en[2] = 1'b0;
      run_scan("multi_no2", 100, 55);

      // No wrap-around near y=0.
      clear_table();
      set_tile(0, 10, 45);
      run_scan("wrap_down", 10, 0);
      set_tile(0, 10, 20);
      run_scan("wrap_up", 10, 0);

      // Randomized tables biased toward touching geometry.
      for (int s = 0; s < 30; s++) begin
         xp = int'($urandom_range(30, 900));
         yp = int'($urandom_range(30, 400));
         for (int i = 0; i < N; i++) begin
            int kind;
            kind = int'($urandom_range(0, 7));
            tab_en[i] = ($urandom_range(0, 1) == 1);
            case (kind)
               0: begin
                  tab_x[i] = X_W'(xp + int'($urandom_range(0, 46)) - 23);
                  tab_y[i] = Y_W'(yp + PH);
               end
               1: begin
                  tab_x[i] = X_W'(xp + int'($urandom_range(0, 46)) - 23);
                  tab_y[i] = Y_W'(yp - TH);
               end
               2: begin
                  tab_x[i] = X_W'(xp + PW);
                  tab_y[i] = Y_W'(yp + int'($urandom_range(0, 68)) - 23);
               end
               3: begin
                  tab_x[i] = X_W'(xp - TW);
                  tab_y[i] = Y_W'(yp + int'($urandom_range(0, 68)) - 23);
               end
               default: begin
                  tab_x[i] = X_W'($urandom);
                  tab_y[i] = Y_W'($urandom);
               end
            endcase
         end
         run_scan($sformatf("rand%0d", s), xp, yp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
